// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine refund path: credit width,
// coin values and one-hot encodings, and the dispenser state type.
package vend_pkg;

    localparam int CREDIT_W   = 5;
    localparam int MAX_CREDIT = 20;

    localparam int COIN4_VAL  = 4;
    localparam int COIN8_VAL  = 8;
    localparam int COIN12_VAL = 12;

    localparam logic [2:0] COIN_NONE = 3'b000;
    localparam logic [2:0] COIN4     = 3'b001;
    localparam logic [2:0] COIN8     = 3'b010;
    localparam logic [2:0] COIN12    = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_OFFER  = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

endpackage

// File: rtl/coin_picker.sv
// Greedy coin selector: largest coin (12, 8, then 4) not exceeding the
// credit still owed.
module coin_picker
    import vend_pkg::*;
#(
    parameter int CREDIT_W = vend_pkg::CREDIT_W
) (
    input  logic [CREDIT_W-1:0] i_remaining,
    output logic [2:0]          o_coin_sel,
    output logic [CREDIT_W-1:0] o_coin_value
);

    // Pick the largest coin that fits into the remaining credit
    always_comb begin
        o_coin_sel   = COIN4;
        o_coin_value = CREDIT_W'(COIN4_VAL);
        if (i_remaining >= CREDIT_W'(COIN12_VAL)) begin
            o_coin_sel   = COIN12;
            o_coin_value = CREDIT_W'(COIN12_VAL);
        end else if (i_remaining >= CREDIT_W'(COIN8_VAL)) begin
            o_coin_sel   = COIN8;
            o_coin_value = CREDIT_W'(COIN8_VAL);
        end else begin
            o_coin_sel   = COIN4;
            o_coin_value = CREDIT_W'(COIN4_VAL);
        end
    end

endmodule

// File: rtl/coin_change_dispenser.sv
// Refund dispenser: breaks a credit into 12/8/4 coins and offers them one at
// a time to the ejector over valid/ack, with an ack timeout into FAULT.
module coin_change_dispenser
    import vend_pkg::*;
#(
    parameter int MAX_CREDIT  = vend_pkg::MAX_CREDIT,
    parameter int CREDIT_W    = vend_pkg::CREDIT_W,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                CLOCK_50,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CREDIT_W-1:0] credit,
    input  logic                clear,
    input  logic                coin_ack,
    output logic                coin_valid,
    output logic [2:0]          coin_sel,
    output logic [CREDIT_W-1:0] remaining,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                fault
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT);

    state_t              r_state, w_state;
    logic [CREDIT_W-1:0] r_remaining, w_remaining;
    logic [TMR_W-1:0]    r_timer, w_timer;
    logic                r_coin_valid, w_coin_valid;
    logic [2:0]          r_coin_sel, w_coin_sel;
    logic                r_busy, w_busy;
    logic                r_done, w_done;
    logic                r_err, w_err;
    logic                r_fault, w_fault;

    logic [2:0]          w_pick_sel;
    logic [CREDIT_W-1:0] w_pick_value;
    logic [CREDIT_W-1:0] w_after_ack;
    logic                w_illegal;

    coin_picker #(.CREDIT_W(CREDIT_W)) u_picker (
        .i_remaining  (r_remaining),
        .o_coin_sel   (w_pick_sel),
        .o_coin_value (w_pick_value)
    );

    assign w_illegal   = (credit > CREDIT_W'(MAX_CREDIT)) || (credit[1:0] != 2'b00);
    // remaining is unchanged while a coin is offered, so the picker still
    // describes the coin on offer and the subtraction cannot underflow
    assign w_after_ack = r_remaining - w_pick_value;

    // State and registered-output update
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_remaining  <= '0;
            r_timer      <= '0;
            r_coin_valid <= 1'b0;
            r_coin_sel   <= COIN_NONE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_remaining  <= w_remaining;
            r_timer      <= w_timer;
            r_coin_valid <= w_coin_valid;
            r_coin_sel   <= w_coin_sel;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_err        <= w_err;
            r_fault      <= w_fault;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state      = r_state;
        w_remaining  = r_remaining;
        w_timer      = r_timer;
        w_coin_valid = r_coin_valid;
        w_coin_sel   = r_coin_sel;
        w_done       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_coin_valid = 1'b0;
                w_coin_sel   = COIN_NONE;
                if (start) begin
                    if (w_illegal) begin
                        w_err = 1'b1;
                    end else if (credit == '0) begin
                        w_done = 1'b1;
                    end else begin
                        w_remaining = credit;
                        w_state     = ST_SELECT;
                    end
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_SELECT: begin
                w_coin_sel   = w_pick_sel;
                w_coin_valid = 1'b1;
                w_timer      = '0;
                w_state      = ST_OFFER;
            end
            ST_OFFER: begin
                // an ack on the timeout edge still counts as accepted
                if (coin_ack && r_coin_valid) begin
                    w_remaining  = w_after_ack;
                    w_coin_valid = 1'b0;
                    w_coin_sel   = COIN_NONE;
                    if (w_after_ack == '0) begin
                        w_done  = 1'b1;
                        w_state = ST_IDLE;
                    end else begin
                        w_state = ST_SELECT;
                    end
                end else if (r_timer == TMR_W'(ACK_TIMEOUT - 1)) begin
                    w_coin_valid = 1'b0;
                    w_coin_sel   = COIN_NONE;
                    w_state      = ST_FAULT;
                end else begin
                    w_timer = r_timer + TMR_W'(1);
                end
            end
            ST_FAULT: begin
                w_coin_valid = 1'b0;
                w_coin_sel   = COIN_NONE;
                if (clear) begin
                    w_state = ST_SELECT;
                end else begin
                    w_state = ST_FAULT;
                end
            end
            default: begin
                w_state      = ST_IDLE;
                w_remaining  = '0;
                w_timer      = '0;
                w_coin_valid = 1'b0;
                w_coin_sel   = COIN_NONE;
            end
        endcase
        w_busy  = (w_state != ST_IDLE);
        w_fault = (w_state == ST_FAULT);
    end

    assign coin_valid = r_coin_valid;
    assign coin_sel   = r_coin_sel;
    assign remaining  = r_remaining;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign fault      = r_fault;

endmodule
